hilo_ctrl: RTL and testbench
============================

# hilo_ctrl

Sequencer and architectural HI/LO register file for the multiply path. It accepts MULT/MTHI/MTLO operations from the control unit and issues the one-cycle start pulse and operands to the 32-step Booth multiplier. It counts the multiplier's fixed latency, because the multiplier has no done output, then captures its Hi/Lo into the architectural HI/LO registers. It serves MFHI/MFLO reads and stalls readers while a multiply is in flight.

## Interface
Parameters:
- MULT_STEPS, 32, number of multiplier shift steps after it samples start (counter width = $clog2(MULT_STEPS)+1)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- op_valid  in  1  operation request
- op  in  2  00 NOP, 01 MULT, 10 MTHI, 11 MTLO
- rs_data  in  32  MULT multiplier / MTHI, MTLO source
- rt_data  in  32  MULT multiplicand
- op_ready  out  1  high only in IDLE; request accepted when op_valid && op_ready at a rising edge
- mult_start  out  1  registered; drives the multiplier's start (MultControl)
- mult_a  out  32  registered multiplier operand (EntrA)
- mult_b  out  32  registered multiplicand operand (EntrB)
- mult_hi  in  32  multiplier Hi output
- mult_lo  in  32  multiplier Lo output
- rd_sel  in  1  0 selects LO, 1 selects HI
- rd_data  out  32  combinational: rd_sel ? hi : lo
- rd_stall  out  1  equals busy; MFHI/MFLO must wait
- busy  out  1  multiply in flight (state != IDLE)
- done  out  1  one-cycle pulse after HI/LO capture
- hi, lo  out  32 each  architectural registers

## Operation
- States: IDLE, START, WAIT, CAPTURE.
- IDLE:
  - Accepted MULT: mult_a<=rs_data, mult_b<=rt_data, mult_start<=1, go to START.
  - Accepted MTHI: hi<=rs_data, stay in IDLE.
  - Accepted MTLO: lo<=rs_data, stay in IDLE.
  - NOP: ignored.
- START: mult_start<=0, cnt<=MULT_STEPS, go to WAIT. The multiplier samples its operands at this edge.
- WAIT: cnt<=cnt-1 each edge. At the edge where cnt==1 (cnt reaches 0), go to CAPTURE.
- CAPTURE: hi<=mult_hi, lo<=mult_lo, done<=1, go to IDLE.
- done clears on the next edge.
- Operands are signed 32-bit. The product is 64-bit two's complement {hi,lo}. No width conversion in this block.
- op_valid while busy: not accepted, no side effect. The requester holds the request until op_ready.
- Reset at any time, including mid-multiply:
  - state=IDLE, hi=lo=0, mult_a=mult_b=0, mult_start=0, cnt=0, done=0.
  - The multiplier shares reset, so no stale capture can occur.
- mult_hi/mult_lo are ignored outside CAPTURE.

## Timing
- E0 = edge accepting MULT.
- mult_start high for exactly the cycle E0–E1.
- Multiplier loads at E1 and steps at E2..E33, with its Hi/Lo valid after E33.
- Capture at E34. hi/lo visible and done high in cycle E34–E35. MULT latency is 34 edges (2+MULT_STEPS).
- busy/rd_stall high from after E0 through E34; op_ready low during the same interval.
- A new op may be accepted at E35, the cycle done is high.
- MTHI/MTLO: value visible one edge after acceptance; busy never rises.
- rd_data is combinational. A read in the cycle after an MTHI write returns the new value.

## Structure
- Package hilo_pkg:
  - op encoding constants (OP_NOP, OP_MULT, OP_MTHI, OP_MTLO)
  - state enum
  - default MULT_STEPS
- Single module, no sub-module. The cycle counter is inline.
- The multiplier is instantiated beside this block at the datapath level, not inside it.

## Test plan
- Reset then MULT rs=7, rt=0xFFFFFFFD:
  - mult_start high exactly one cycle.
  - busy for 34 edges.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB; done one cycle.
- MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0x00000000. MULT 0xFFFFFFFF × 0xFFFFFFFF -> hi=0, lo=1.
- MTHI 0xDEADBEEF, then MTLO 0x12345678 on consecutive edges -> rd_sel=1 gives 0xDEADBEEF, rd_sel=0 gives 0x12345678; busy stays 0.
- MULT in flight, MTLO 0x55 held with op_valid:
  - not accepted until op_ready.
  - At E34 lo = product low; MTLO accepted at E35, then lo=0x55.
- Assert reset at E20 of a MULT -> all outputs 0 and op_ready=1 immediately; no done pulse; hi/lo remain 0.
- Back-to-back MULTs: second accepted at E35 -> second result captured 34 edges later; first result visible in between.

Source files
------------

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO multiply sequencer.
//   - op_t / OP_* : operation encoding presented by the control unit
//   - state_t     : sequencer states
//   - MULT_STEPS_DEF : default number of multiplier shift steps
package hilo_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_NOP  = 2'b00;
  localparam op_t OP_MULT = 2'b01;
  localparam op_t OP_MTHI = 2'b10;
  localparam op_t OP_MTLO = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_START   = 2'b01,
    ST_WAIT    = 2'b10,
    ST_CAPTURE = 2'b11
  } state_t;

  localparam int MULT_STEPS_DEF = 32;

endpackage

// File: rtl/hilo_ctrl_if.sv
// hilo_ctrl_if: request / read bus between the control unit and hilo_ctrl.
//   op_valid, op, rs_data, rt_data : operation request (held until op_ready)
//   op_ready                       : request accepted on valid && ready at an edge
//   rd_sel, rd_data, rd_stall      : MFHI/MFLO read port (1 = HI, 0 = LO)
// Modports: master = control unit side, slave = hilo_ctrl side.
interface hilo_ctrl_if;
  import hilo_pkg::*;

  logic        op_valid;
  op_t         op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        op_ready;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        rd_stall;

  modport master (
    output op_valid, op, rs_data, rt_data, rd_sel,
    input  op_ready, rd_data, rd_stall
  );

  modport slave (
    input  op_valid, op, rs_data, rt_data, rd_sel,
    output op_ready, rd_data, rd_stall
  );

endinterface

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: sequencer and architectural HI/LO registers for the multiply path.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   bus (slave)       : operation request and MFHI/MFLO read port
//   mult_start        : one-cycle start pulse to the Booth multiplier
//   mult_a, mult_b    : registered multiplier / multiplicand operands
//   mult_hi, mult_lo  : multiplier result, sampled only in CAPTURE
//   busy              : multiply in flight
//   done              : one-cycle pulse after HI/LO capture
//   hi, lo            : architectural registers
// The multiplier has no done output, so its fixed latency is counted here.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int MULT_STEPS = MULT_STEPS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  hilo_ctrl_if.slave  bus,
  output logic        mult_start,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(MULT_STEPS) + 1;
  localparam logic [CNT_W-1:0] STEPS_C = CNT_W'(MULT_STEPS);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      mult_a_q;
  logic [31:0]      mult_b_q;
  logic             mult_start_q;
  logic             done_q;

  // Sequencer FSM, cycle counter and architectural registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      hi_q         <= 32'h0000_0000;
      lo_q         <= 32'h0000_0000;
      mult_a_q     <= 32'h0000_0000;
      mult_b_q     <= 32'h0000_0000;
      mult_start_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only CAPTURE raises it again.
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.op_valid) begin
            case (bus.op)
              OP_MULT: begin
                mult_a_q     <= bus.rs_data;
                mult_b_q     <= bus.rt_data;
                mult_start_q <= 1'b1;
                state_q      <= ST_START;
              end
              OP_MTHI: hi_q <= bus.rs_data;
              OP_MTLO: lo_q <= bus.rs_data;
              default: ;
            endcase
          end else begin
            state_q <= ST_IDLE;
          end
        end
        // Multiplier samples start and operands at this edge.
        ST_START: begin
          mult_start_q <= 1'b0;
          cnt_q        <= STEPS_C;
          state_q      <= ST_WAIT;
        end
        // One edge per multiplier shift step; leave when the last step lands.
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_CAPTURE;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_CAPTURE: begin
          hi_q    <= mult_hi;
          lo_q    <= mult_lo;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q      <= ST_IDLE;
          mult_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_ready = (state_q == ST_IDLE);
  assign bus.rd_stall = (state_q != ST_IDLE);
  assign bus.rd_data  = bus.rd_sel ? hi_q : lo_q;

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign mult_a     = mult_a_q;
  assign mult_b     = mult_b_q;
  assign mult_start = mult_start_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: self-checking bench for hilo_ctrl. A behavioural 32-step
// multiplier sits beside the DUT and shows junk on Hi/Lo until its steps
// complete; expected HI/LO come from plain signed 64-bit arithmetic.
module tb_hilo_ctrl;
  import hilo_pkg::*;

  localparam int STEPS = 32;
  localparam int LAT   = STEPS + 2;

  logic        clk;
  logic        reset;
  logic        mult_start;
  logic [31:0] mult_a, mult_b, mult_hi, mult_lo;
  logic        busy, done;
  logic [31:0] hi, lo;

  hilo_ctrl_if bus ();

  hilo_ctrl #(.MULT_STEPS(STEPS)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .mult_start(mult_start),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_hi   (mult_hi),
    .mult_lo   (mult_lo),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier: samples start, steps STEPS times, then holds product.
  int          m_steps;
  bit          m_valid;
  logic [63:0] m_prod;
  logic [63:0] m_junk;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_steps <= 0;
      m_valid <= 1'b0;
      m_prod  <= 64'd0;
    end else if (mult_start) begin
      m_prod  <= 64'(longint'($signed(mult_a)) * longint'($signed(mult_b)));
      m_steps <= STEPS;
      m_valid <= 1'b0;
    end else if (m_steps != 0) begin
      m_steps <= m_steps - 1;
      if (m_steps == 1) m_valid <= 1'b1;
    end
  end
  always @(posedge clk) m_junk <= {$urandom, $urandom};
  assign mult_hi = m_valid ? m_prod[63:32] : m_junk[63:32];
  assign mult_lo = m_valid ? m_prod[31:0]  : m_junk[31:0];

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi, exp_lo;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reads(input string tag);
    bus.rd_sel = 1'b1;
    #1 chk({tag, "_rdhi"}, 64'(bus.rd_data), 64'(exp_hi));
    bus.rd_sel = 1'b0;
    #1 chk({tag, "_rdlo"}, 64'(bus.rd_data), 64'(exp_lo));
  endtask

  // MTHI/MTLO: value visible one edge after acceptance, busy stays low.
  task automatic do_mt(input bit to_hi, input logic [31:0] val);
    bus.op_valid = 1'b1;
    bus.op       = to_hi ? OP_MTHI : OP_MTLO;
    bus.rs_data  = val;
    tick();
    bus.op_valid = 1'b0;
    if (to_hi) exp_hi = val; else exp_lo = val;
    chk("mt_hi", 64'(hi), 64'(exp_hi));
    chk("mt_lo", 64'(lo), 64'(exp_lo));
    chk("mt_busy", 64'(busy), 64'd0);
    chk("mt_ready", 64'(bus.op_ready), 64'd1);
  endtask

  // MULT from acceptance to done; optionally holds an MTLO request during flight.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                         input bit hold_mtlo, input logic [31:0] mtlo_val);
    logic [63:0] p;
    int k, starts, busys;
    bit seen, flight_ok;
    p = 64'(longint'($signed(a)) * longint'($signed(b)));
    chk("mult_pre_ready", 64'(bus.op_ready), 64'd1);
    bus.op_valid = 1'b1;
    bus.op       = OP_MULT;
    bus.rs_data  = a;
    bus.rt_data  = b;
    tick();  // E0
    if (hold_mtlo) begin
      bus.op      = OP_MTLO;
      bus.rs_data = mtlo_val;
    end else begin
      bus.op_valid = 1'b0;
    end
    starts = int'(mult_start);
    busys  = int'(busy);
    chk("mult_a", 64'(mult_a), 64'(a));
    chk("mult_b", 64'(mult_b), 64'(b));
    k = 0;
    seen = 1'b0;
    flight_ok = 1'b1;
    while (!seen && k < 60) begin
      if (bus.op_ready !== 1'b0 || bus.rd_stall !== 1'b1 ||
          hi !== exp_hi || lo !== exp_lo || done !== 1'b0)
        flight_ok = 1'b0;
      tick();
      k++;
      if (done === 1'b1) seen = 1'b1;
      else begin
        starts += int'(mult_start);
        busys  += int'(busy);
      end
    end
    exp_hi = p[63:32];
    exp_lo = p[31:0];
    chk("mult_latency", 64'(k), 64'(LAT));
    chk("mult_start_cycles", 64'(starts), 64'd1);
    chk("mult_busy_cycles", 64'(busys), 64'(LAT));
    chk("mult_flight", 64'(flight_ok), 64'd1);
    chk("mult_hi", 64'(hi), 64'(exp_hi));
    chk("mult_lo", 64'(lo), 64'(exp_lo));
    chk("mult_idle_busy", 64'(busy), 64'd0);
    chk("mult_idle_ready", 64'(bus.op_ready), 64'd1);
    if (hold_mtlo) begin
      tick();  // E35: held MTLO accepted
      bus.op_valid = 1'b0;
      exp_lo = mtlo_val;
      chk("held_mtlo_lo", 64'(lo), 64'(exp_lo));
      chk("held_mtlo_hi", 64'(hi), 64'(exp_hi));
      chk("done_clear", 64'(done), 64'd0);
    end
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int k;
    bit dirty;
    reset = 1'b1;
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
    bus.rs_data  = 32'd0;
    bus.rt_data  = 32'd0;
    bus.rd_sel   = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    repeat (2) tick();
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(bus.op_ready), 64'd1);
    chk("rst_start", 64'(mult_start), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    tick();

    // Directed products from the test plan.
    do_mult(32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 32'd0);
    tick();
    chk("done_one_cycle", 64'(done), 64'd0);
    do_mult(32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0);
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0);  // back-to-back at E35
    tick();

    // MTHI then MTLO on consecutive edges.
    do_mt(1'b1, 32'hDEAD_BEEF);
    do_mt(1'b0, 32'h1234_5678);
    check_reads("mt_pair");

    // MULT with a held MTLO of 0x55.
    do_mult(32'h0001_2345, 32'hFFFE_0001, 1'b1, 32'h0000_0055);
    check_reads("held");

    // Reset asserted at E20 of a MULT.
    bus.op_valid = 1'b1;
    bus.op       = OP_MULT;
    bus.rs_data  = 32'h1234_5678;
    bus.rt_data  = 32'h0000_0100;
    tick();
    bus.op_valid = 1'b0;
    repeat (20) tick();
    reset = 1'b1;
    #1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(bus.op_ready), 64'd1);
    chk("midrst_start", 64'(mult_start), 64'd0);
    chk("midrst_ops", {mult_a, mult_b}, 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    repeat (2) tick();
    reset = 1'b0;
    dirty = 1'b0;
    for (k = 0; k < 40; k++) begin
      tick();
      if (done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) dirty = 1'b1;
    end
    chk("midrst_quiet", 64'(dirty), 64'd0);

    // Randomized operation mix.
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          bus.op_valid = 1'b1;
          bus.op       = OP_NOP;
          bus.rs_data  = 32'($urandom);
          tick();
          bus.op_valid = 1'b0;
          chk("nop_hilo", {hi, lo}, {exp_hi, exp_lo});
          chk("nop_busy", 64'(busy), 64'd0);
        end
        1: do_mult(pick_val(), pick_val(), 1'($urandom_range(0, 1)), 32'($urandom));
        2: do_mt(1'b1, 32'($urandom));
        default: do_mt(1'b0, 32'($urandom));
      endcase
      check_reads("rand");
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
